// File: rtl/forward_ctrl_pkg.sv
// Shared CPU definitions for the EX-stage forwarding controller: operand-mux
// select encodings, pipeline slot record and slot helpers.
package forward_ctrl_pkg;

  localparam int CPU_REG_AW = 6;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [CPU_REG_AW-1:0] rd;
    logic                  we;
    logic                  load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: {CPU_REG_AW{1'b0}}, we: 1'b0, load: 1'b0};

  function automatic logic slot_writes(input slot_t s, input logic [CPU_REG_AW-1:0] r);
    return s.valid & s.we & (s.rd == r);
  endfunction

endpackage

// File: rtl/forward_ctrl_if.sv
// Decode-to-forwarding handshake: decode fields in, operand selects and stall out.
interface forward_ctrl_if #(
  parameter int REG_AW = forward_ctrl_pkg::CPU_REG_AW
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_load;
  logic              flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_we, id_load, flush,
    input  fwd_a, fwd_b, stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_we, id_load, flush,
    output fwd_a, fwd_b, stall
  );
endinterface

// File: rtl/forward_ctrl_hazard.sv
// hazard_cmp: compares one decode source operand against the EX and MEM slots.
import forward_ctrl_pkg::*;

module hazard_cmp (
  input  logic [CPU_REG_AW-1:0] src,
  input  logic                  src_used,
  input  logic                  id_valid,
  input  slot_t                 ex_slot,
  input  slot_t                 mem_slot,
  output logic                  ex_fwd,
  output logic                  mem_match,
  output logic                  load_use
);

  logic ex_match_s;
  logic unused_mem_load_s;

  assign ex_match_s = slot_writes(ex_slot, src);
  assign ex_fwd     = src_used & ex_match_s;
  assign mem_match  = slot_writes(mem_slot, src);
  // A load in EX has no result yet, so a real reader of its rd must wait.
  assign load_use   = id_valid & src_used & ex_match_s & ex_slot.load;

  // The MEM slot keeps its load flag for completeness; forwarding never needs it.
  assign unused_mem_load_s = mem_slot.load;

endmodule

// File: rtl/forward_ctrl.sv
// EX/MEM forwarding and load-use stall controller.
// Define FWD_MEMWB_EN to forward from MEM/WB; otherwise MEM hits stall decode.
import forward_ctrl_pkg::*;

module forward_ctrl #(
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic           clk,
  input  logic           rst_n,
  forward_ctrl_if.slave  bus
);

  slot_t                 ex_r;
  slot_t                 mem_r;
  fwd_sel_t              fwd_a_r;
  fwd_sel_t              fwd_b_r;
  fwd_sel_t              fwd_a_nxt_s;
  fwd_sel_t              fwd_b_nxt_s;
  logic                  stall_s;
  logic [REG_AW-1:0]     id_rs_s;
  logic [REG_AW-1:0]     id_rt_s;
  logic [REG_AW-1:0]     id_rd_s;
  logic                  ex_fwd_a_s;
  logic                  ex_fwd_b_s;
  logic                  mem_match_a_s;
  logic                  mem_match_b_s;
  logic                  load_use_a_s;
  logic                  load_use_b_s;

  assign id_rs_s = bus.id_rs;
  assign id_rt_s = bus.id_rt;
  assign id_rd_s = bus.id_rd;

  hazard_cmp u_cmp_a (
    .src       (CPU_REG_AW'(id_rs_s)),
    .src_used  (bus.id_rs_used),
    .id_valid  (bus.id_valid),
    .ex_slot   (ex_r),
    .mem_slot  (mem_r),
    .ex_fwd    (ex_fwd_a_s),
    .mem_match (mem_match_a_s),
    .load_use  (load_use_a_s)
  );

  hazard_cmp u_cmp_b (
    .src       (CPU_REG_AW'(id_rt_s)),
    .src_used  (bus.id_rt_used),
    .id_valid  (bus.id_valid),
    .ex_slot   (ex_r),
    .mem_slot  (mem_r),
    .ex_fwd    (ex_fwd_b_s),
    .mem_match (mem_match_b_s),
    .load_use  (load_use_b_s)
  );

  // Stall and next operand selects for the instruction now in decode.
  always_comb begin
    stall_s     = load_use_a_s | load_use_b_s;
    fwd_a_nxt_s = FWD_RF;
    fwd_b_nxt_s = FWD_RF;
`ifdef FWD_MEMWB_EN
    if (ex_fwd_a_s) begin
      fwd_a_nxt_s = FWD_EXMEM;
    end else if (mem_match_a_s) begin
      fwd_a_nxt_s = FWD_MEMWB;
    end else begin
      fwd_a_nxt_s = FWD_RF;
    end
    if (ex_fwd_b_s) begin
      fwd_b_nxt_s = FWD_EXMEM;
    end else if (mem_match_b_s) begin
      fwd_b_nxt_s = FWD_MEMWB;
    end else begin
      fwd_b_nxt_s = FWD_RF;
    end
`else
    // Without a MEM/WB path, a reader must wait until the producer retires.
    stall_s = stall_s
            | (bus.id_valid & bus.id_rs_used & mem_match_a_s & ~ex_fwd_a_s)
            | (bus.id_valid & bus.id_rt_used & mem_match_b_s & ~ex_fwd_b_s);
    fwd_a_nxt_s = ex_fwd_a_s ? FWD_EXMEM : FWD_RF;
    fwd_b_nxt_s = ex_fwd_b_s ? FWD_EXMEM : FWD_RF;
`endif
    if (stall_s || !bus.id_valid) begin
      fwd_a_nxt_s = FWD_RF;
      fwd_b_nxt_s = FWD_RF;
    end else begin
      fwd_a_nxt_s = fwd_a_nxt_s;
      fwd_b_nxt_s = fwd_b_nxt_s;
    end
  end

  // Pipeline slots and registered selects; flush beats stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r    <= SLOT_EMPTY;
      mem_r   <= SLOT_EMPTY;
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else if (bus.flush) begin
      ex_r    <= SLOT_EMPTY;
      mem_r   <= SLOT_EMPTY;
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else begin
      mem_r   <= ex_r;
      fwd_a_r <= fwd_a_nxt_s;
      fwd_b_r <= fwd_b_nxt_s;
      if (stall_s) begin
        ex_r <= SLOT_EMPTY;
      end else begin
        ex_r <= '{valid: bus.id_valid, rd: CPU_REG_AW'(id_rd_s),
                  we: bus.id_we & bus.id_valid, load: bus.id_load};
      end
    end
  end

  assign bus.fwd_a = fwd_a_r;
  assign bus.fwd_b = fwd_b_r;
  assign bus.stall = stall_s;

endmodule

// File: tb/tb_forward_ctrl.sv
// Scoreboard bench for forward_ctrl: directed hazard scenarios then random decode traffic.
module tb_forward_ctrl;

  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } ins_t;

  typedef struct {
    bit v;
    int rs;
    int rt;
    bit rsu;
    bit rtu;
    int rd;
    bit we;
    bit ld;
    bit fl;
  } stim_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  forward_ctrl_if #(.REG_AW(6)) bus ();

  forward_ctrl #(.REG_AW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: instructions in flight, youngest first (EX, then MEM).
  ins_t pipe[$];
  int   exp_fa;
  int   exp_fb;
  bit   last_stall;
  int   fa_q[$];
  int   fb_q[$];
  bit   st_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit writes(input ins_t i, input int r);
    return i.v && i.we && (i.rd == r);
  endfunction

  function automatic int model_sel(input int src, input bit used);
    if (used && writes(pipe[0], src)) return 1;
`ifdef FWD_MEMWB_EN
    if (writes(pipe[1], src)) return 2;
`endif
    return 0;
  endfunction

  function automatic bit model_stall(input stim_t s);
    int src[2];
    bit used[2];
    bit st;
    src[0] = s.rs; src[1] = s.rt;
    used[0] = s.rsu; used[1] = s.rtu;
    st = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (s.v && used[k] && writes(pipe[0], src[k]) && pipe[0].ld) st = 1'b1;
`ifndef FWD_MEMWB_EN
      if (s.v && used[k] && !writes(pipe[0], src[k]) && writes(pipe[1], src[k])) st = 1'b1;
`endif
    end
    return st;
  endfunction

  function automatic void model_clear();
    ins_t b;
    b = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
    pipe.delete();
    pipe.push_back(b);
    pipe.push_back(b);
    exp_fa = 0;
    exp_fb = 0;
  endfunction

  // Monitor: compare DUT outputs against expectations away from the active edge.
  always @(negedge clk) begin
    if (fa_q.size() > 0) begin
      chk("fwd_a", int'(bus.fwd_a), fa_q.pop_front());
      chk("fwd_b", int'(bus.fwd_b), fb_q.pop_front());
    end
    if (st_q.size() > 0) begin
      chk("stall", int'(bus.stall), int'(st_q.pop_front()));
    end
  end

  task automatic step(input stim_t s, input bit do_rst);
    ins_t ent;
    bit   st;
    int   na;
    int   nb;
    @(posedge clk);
    #1;
    bus.id_valid   = s.v;
    bus.id_rs      = 6'(s.rs);
    bus.id_rt      = 6'(s.rt);
    bus.id_rs_used = s.rsu;
    bus.id_rt_used = s.rtu;
    bus.id_rd      = 6'(s.rd);
    bus.id_we      = s.we;
    bus.id_load    = s.ld;
    bus.flush      = s.fl;
    if (do_rst) begin
      #1 rst_n = 1'b0;
      #1;
      chk("rst_fwd_a", int'(bus.fwd_a), 0);
      chk("rst_fwd_b", int'(bus.fwd_b), 0);
      chk("rst_stall", int'(bus.stall), 0);
      model_clear();
      rst_n = 1'b1;
      #1;
    end
    fa_q.push_back(exp_fa);
    fb_q.push_back(exp_fb);
    st = model_stall(s);
    st_q.push_back(st);
    last_stall = st;
    if (s.fl) begin
      model_clear();
    end else begin
      na = (st || !s.v) ? 0 : model_sel(s.rs, s.rsu);
      nb = (st || !s.v) ? 0 : model_sel(s.rt, s.rtu);
      if (st) ent = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
      else    ent = '{v: s.v, rd: s.rd, we: s.we && s.v, ld: s.ld};
      pipe.push_front(ent);
      void'(pipe.pop_back());
      exp_fa = na;
      exp_fb = nb;
    end
  endtask

  // Issue one instruction, holding it in decode while the model says stall.
  task automatic issue(input stim_t s);
    int guard;
    step(s, 1'b0);
    guard = 0;
    s.fl = 1'b0;
    while (last_stall && guard < 4) begin
      step(s, 1'b0);
      guard++;
    end
    if (last_stall) chk("stall_bound", 1, 0);
  endtask

  function automatic stim_t mk(input bit v, input int rs, input int rt, input bit rsu,
                               input bit rtu, input int rd, input bit we, input bit ld);
    return '{v: v, rs: rs, rt: rt, rsu: rsu, rtu: rtu, rd: rd, we: we, ld: ld, fl: 1'b0};
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.v   = ($urandom_range(0, 3) != 0);
    s.rs  = $urandom_range(0, 3);
    s.rt  = $urandom_range(0, 3);
    s.rsu = s.v && $urandom_range(0, 1) == 1;
    s.rtu = s.v && $urandom_range(0, 1) == 1;
    s.rd  = $urandom_range(0, 3);
    s.we  = ($urandom_range(0, 3) != 0);
    s.ld  = s.we && ($urandom_range(0, 2) == 0);
    s.fl  = ($urandom_range(0, 30) == 0);
    return s;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    stim_t nop;
    int    drain;
    checks = 0;
    errors = 0;
    last_stall = 1'b0;
    nop = mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    bus.id_valid = 1'b0; bus.id_rs = 6'd0; bus.id_rt = 6'd0;
    bus.id_rs_used = 1'b0; bus.id_rt_used = 1'b0; bus.id_rd = 6'd0;
    bus.id_we = 1'b0; bus.id_load = 1'b0; bus.flush = 1'b0;
    model_clear();
    #3;
    chk("reset_fwd_a", int'(bus.fwd_a), 0);
    chk("reset_fwd_b", int'(bus.fwd_b), 0);
    chk("reset_stall", int'(bus.stall), 0);
    #10 rst_n = 1'b1;

    // add r5; add using r5 as rs
    issue(mk(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b0));
    issue(mk(1'b1, 5, 1, 1'b1, 1'b1, 6, 1'b1, 1'b0));
    // add r5; nop; use r5 as rt
    issue(mk(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b0));
    issue(nop);
    issue(mk(1'b1, 1, 5, 1'b1, 1'b1, 9, 1'b1, 1'b0));
    // load r7; use r7
    issue(mk(1'b1, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b1));
    issue(mk(1'b1, 7, 2, 1'b1, 1'b0, 8, 1'b1, 1'b0));
    // r3 produced by both EX and MEM, then read
    issue(mk(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b0));
    issue(mk(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b0));
    issue(mk(1'b1, 3, 0, 1'b1, 1'b0, 10, 1'b1, 1'b0));
    // flush during a load-use stall
    issue(mk(1'b1, 0, 0, 1'b0, 1'b0, 4, 1'b1, 1'b1));
    s = mk(1'b1, 4, 4, 1'b1, 1'b1, 11, 1'b1, 1'b0);
    step(s, 1'b0);
    s.fl = 1'b1;
    step(s, 1'b0);
    s.fl = 1'b0;
    issue(s);
    // reset pulse with a pending load-use and live forwarding
    issue(mk(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b0));
    issue(mk(1'b1, 5, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1));
    step(mk(1'b1, 2, 2, 1'b1, 1'b1, 12, 1'b1, 1'b0), 1'b1);
    // register 0 is an ordinary register
    issue(mk(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0));
    issue(mk(1'b1, 0, 0, 1'b1, 1'b1, 1, 1'b1, 1'b0));

    for (int n = 0; n < 1500; n++) begin
      if (last_stall) begin
        s.fl = ($urandom_range(0, 30) == 0);
      end else begin
        s = rnd();
      end
      step(s, 1'b0);
    end

    drain = 0;
    while ((fa_q.size() > 0 || st_q.size() > 0) && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    @(posedge clk);
    chk("queues_drained", fa_q.size() + st_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
